// File: rtl/sync_ram.sv
// 256x8 flop-based RAM: one write port, four registered read ports sharing one clock.
// Reads return the pre-write contents when a read and write hit the same address.

module sync_ram_rdport #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                         Clk,
  input  logic                                         nReset,
  input  logic                                         rdEn,
  input  logic [ADDR_WIDTH-1:0]                        addr,
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]   mem,
  output logic [DATA_WIDTH-1:0]                        dOut
);
  always_ff @(posedge Clk) begin
    if (!nReset)   dOut <= '0;
    else if (rdEn) dOut <= mem[addr];
  end
endmodule

module sync_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic                  chipSelect,
  input  logic                  writeEnable,
  input  logic                  readEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0] readAddr_0,
  input  logic [ADDR_WIDTH-1:0] readAddr_1,
  input  logic [ADDR_WIDTH-1:0] readAddr_2,
  input  logic [ADDR_WIDTH-1:0] readAddr_3,
  output logic [DATA_WIDTH-1:0] dOut_0,
  output logic [DATA_WIDTH-1:0] dOut_1,
  output logic [DATA_WIDTH-1:0] dOut_2,
  output logic [DATA_WIDTH-1:0] dOut_3
);
  localparam int DEPTH     = 2**ADDR_WIDTH;
  localparam int NUM_PORTS = 4;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]     mem;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rdAddr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdData;
  logic                                 rdEn;

  assign rdAddr = {readAddr_3, readAddr_2, readAddr_1, readAddr_0};
  assign rdEn   = chipSelect & readEnable;

  // Whole array is flops so reset can clear every word in one edge.
  always_ff @(posedge Clk) begin
    if (!nReset)                         mem <= '0;
    else if (chipSelect && writeEnable)  mem[writeAddr] <= dataIn;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    sync_ram_rdport #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd (
      .Clk    (Clk),
      .nReset (nReset),
      .rdEn   (rdEn),
      .addr   (rdAddr[p]),
      .mem    (mem),
      .dOut   (rdData[p])
    );
  end

  assign dOut_0 = rdData[0];
  assign dOut_1 = rdData[1];
  assign dOut_2 = rdData[2];
  assign dOut_3 = rdData[3];
endmodule

// File: tb/tb_sync_ram.sv
// Directed bench for sync_ram: stimulus pushes expected dOut per cycle, a monitor
// pops and compares 1ns after the matching rising edge.

module tb_sync_ram;
  logic       Clk = 1'b0;
  logic       nReset, chipSelect, writeEnable, readEnable;
  logic [7:0] writeAddr, dataIn;
  logic [7:0] readAddr_0, readAddr_1, readAddr_2, readAddr_3;
  logic [7:0] dOut_0, dOut_1, dOut_2, dOut_3;

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] e [4];
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   vecId  = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 Clk = ~Clk;

  sync_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .Clk         (Clk),
    .nReset      (nReset),
    .chipSelect  (chipSelect),
    .writeEnable (writeEnable),
    .readEnable  (readEnable),
    .writeAddr   (writeAddr),
    .dataIn      (dataIn),
    .readAddr_0  (readAddr_0),
    .readAddr_1  (readAddr_1),
    .readAddr_2  (readAddr_2),
    .readAddr_3  (readAddr_3),
    .dOut_0      (dOut_0),
    .dOut_1      (dOut_1),
    .dOut_2      (dOut_2),
    .dOut_3      (dOut_3)
  );

  // Drive one cycle of inputs; if chk, expect e0..e3 on dOut after the next edge.
  task automatic step(input logic rn, cs, we, re,
                      input logic [7:0] wa, di, a0, a1, a2, a3,
                      input bit chk, input logic [7:0] e0, e1, e2, e3);
    exp_t x;
    @(negedge Clk);
    nReset = rn; chipSelect = cs; writeEnable = we; readEnable = re;
    writeAddr = wa; dataIn = di;
    readAddr_0 = a0; readAddr_1 = a1; readAddr_2 = a2; readAddr_3 = a3;
    if (chk) begin
      x.cyc = cyc + 1; x.id = vecId;
      x.e[0] = e0; x.e[1] = e1; x.e[2] = e2; x.e[3] = e3;
      q.push_back(x);
      vecId++;
    end
  endtask

  task automatic wr(input logic [7:0] wa, di);
    step(1, 1, 1, 0, wa, di, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [7:0] a0, a1, a2, a3, e0, e1, e2, e3);
    step(1, 1, 0, 1, 0, 0, a0, a1, a2, a3, 1, e0, e1, e2, e3);
  endtask

  initial begin : monitor
    logic [7:0] got [4];
    exp_t x;
    forever begin
      @(posedge Clk);
      cyc++;
      #1;
      got[0] = dOut_0; got[1] = dOut_1; got[2] = dOut_2; got[3] = dOut_3;
      while (q.size() != 0 && q[0].cyc <= cyc) begin
        x = q.pop_front();
        for (int p = 0; p < 4; p++) begin
          checks++;
          if (x.cyc != cyc || got[p] !== x.e[p]) begin
            errors++;
            $display("FAIL vec%0d port%0d: got %02h expected %02h (cycle %0d)",
                     x.id, p, got[p], x.e[p], cyc);
          end
        end
      end
    end
  end

  initial begin : stim
    nReset = 0; chipSelect = 0; writeEnable = 0; readEnable = 0;
    writeAddr = 0; dataIn = 0;
    readAddr_0 = 0; readAddr_1 = 0; readAddr_2 = 0; readAddr_3 = 0;

    // Reset for two edges; the op on the second reset edge is discarded.
    step(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 8'h00, 8'hFF, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    rd(8'h00, 8'h7F, 8'h80, 8'hFF, 0, 0, 0, 0);

    // Writes then rotating reads.
    wr(0, 8'h00); wr(1, 8'h01); wr(2, 8'h10); wr(3, 8'h06); wr(4, 8'h12);
    rd(1, 2, 3, 4, 8'h01, 8'h10, 8'h06, 8'h12);
    rd(4, 1, 2, 3, 8'h12, 8'h01, 8'h10, 8'h06);
    rd(3, 4, 1, 2, 8'h06, 8'h12, 8'h01, 8'h10);
    rd(2, 3, 4, 1, 8'h10, 8'h06, 8'h12, 8'h01);

    // chipSelect=0 blocks the write and the read.
    step(1, 0, 1, 1, 8'h01, 8'hAA, 4, 4, 4, 4, 1, 8'h10, 8'h06, 8'h12, 8'h01);
    rd(1, 1, 1, 1, 8'h01, 8'h01, 8'h01, 8'h01);
    // readEnable=0 holds outputs.
    step(1, 1, 0, 0, 8'h00, 8'h00, 2, 3, 4, 0, 1, 8'h01, 8'h01, 8'h01, 8'h01);

    // Read-before-write collision.
    step(1, 1, 1, 0, 8'h05, 8'h33, 5, 5, 5, 5, 1, 8'h01, 8'h01, 8'h01, 8'h01);
    step(1, 1, 1, 1, 8'h05, 8'h44, 5, 5, 5, 5, 1, 8'h33, 8'h33, 8'h33, 8'h33);
    rd(5, 5, 5, 5, 8'h44, 8'h44, 8'h44, 8'h44);

    // Address extremes.
    wr(8'hFF, 8'h5A); wr(8'h00, 8'hA5);
    rd(8'hFF, 8'h00, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h5A, 8'hA5);

    // Reset in the middle of a write burst.
    wr(8'h10, 8'h11);
    step(0, 1, 1, 1, 8'h11, 8'h22, 8'hFF, 0, 8'hFF, 0, 1, 0, 0, 0, 0);
    rd(0, 1, 2, 3, 0, 0, 0, 0);
    rd(4, 5, 8'hFF, 8'h10, 0, 0, 0, 0);
    rd(8'h11, 8'h11, 8'h00, 8'h00, 0, 0, 0, 0);

    // Operation resumes after reset.
    wr(3, 8'h77);
    rd(3, 0, 3, 0, 8'h77, 8'h00, 8'h77, 8'h00);

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge Clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: timeout at cycle %0d, required completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
